col2im_accum: RTL and testbench

Accumulating column-to-image converter: the inverse of the im2Col stage. It consumes a raster-ordered stream of 3x3 int8 window vectors (stride 1, no padding) and scatters each window onto an IMG_H x IMG_W image, summing overlapping contributions. It emits completed image rows as a signed pixel stream. It sits after the MAC array on the transposed-conv/gradient path, producing feature maps for the next layer.

---
 rtl/col2im_accum_pkg.sv | 28 ++
 rtl/col2im_accum_rowbuf.sv | 51 +++++
 rtl/col2im_accum.sv | 161 ++++++++++++++++
 tb/tb_col2im_accum.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/col2im_accum_pkg.sv
// Shared definitions for the accumulating column-to-image converter:
// kernel size, window element indexing, row-slot arithmetic and FSM states.
package col2ImPkg;

    localparam int K         = 3;
    localparam int ACC_W_DEF = 12;

    typedef logic signed [ACC_W_DEF-1:0] accT;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int elemIdx(input int kr, input int kc);
        return kr * K + kc;
    endfunction

    // Kernel row that lands in buffer `slot` when the window's top row sits in `base_slot`.
    function automatic int laneRow(input int slot, input int base_slot);
        return (slot + K - base_slot) % K;
    endfunction

    function automatic logic [1:0] slotInc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/col2im_accum_rowbuf.sv
// One image row of accumulators: a 3-lane add port for one kernel row of a
// window, and a read port whose entry is cleared when it is consumed.
module col2ImRowBuf
    import col2ImPkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12,
    parameter int CW     = $clog2(IMG_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  add_en_i,
    input  logic [CW-1:0]         add_col_i,
    input  logic [K*DATA_W-1:0]   add_data_i,
    input  logic                  clr_en_i,
    input  logic [CW-1:0]         rd_col_i,
    output logic [ACC_W-1:0]      rd_data_o
);

    logic [ACC_W-1:0] mem_q [IMG_W];
    logic [ACC_W-1:0] mem_d [IMG_W];

    // Clear and add never target the same row in one cycle; add is applied last.
    always_comb begin
        mem_d = mem_q;
        if (clr_en_i) begin
            mem_d[rd_col_i] = '0;
        end
        if (add_en_i) begin
            for (int k = 0; k < K; k++) begin
                mem_d[add_col_i + CW'(k)] = mem_q[add_col_i + CW'(k)]
                    + {{(ACC_W-DATA_W){add_data_i[k*DATA_W + DATA_W-1]}},
                       add_data_i[k*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IMG_W; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q[rd_col_i];

endmodule

// File: rtl/col2im_accum.sv
// Accumulating col2im: scatters 3x3 windows into three rotating row buffers
// and drains each completed image row as a pixel stream.
module col2im_accum
    import col2ImPkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [9*DATA_W-1:0]      iData,
    input  logic                     iValid,
    output logic                     oReady,
    output logic signed [ACC_W-1:0]  oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oLast
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] WC_LAST  = CW'(IMG_W-3);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W-1);
    localparam logic [RW-1:0] WR_LAST  = RW'(IMG_H-3);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);

    state_e          state_q, state_d;
    logic [CW-1:0]   wc_q, wc_d, col_q, col_d;
    logic [RW-1:0]   wr_q, wr_d, drain_row_q, drain_row_d;
    logic [1:0]      wr_slot_q, wr_slot_d, drain_slot_q, drain_slot_d;
    logic [1:0]      rows_left_q, rows_left_d;
    logic            add_en, clr_en;

    logic [K*DATA_W-1:0] lane_data [K];
    logic [ACC_W-1:0]    rd_data   [K];

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q      <= ACCUM;
            wc_q         <= '0;
            wr_q         <= '0;
            col_q        <= '0;
            drain_row_q  <= '0;
            wr_slot_q    <= '0;
            drain_slot_q <= '0;
            rows_left_q  <= '0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            wr_q         <= wr_d;
            col_q        <= col_d;
            drain_row_q  <= drain_row_d;
            wr_slot_q    <= wr_slot_d;
            drain_slot_q <= drain_slot_d;
            rows_left_q  <= rows_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        wr_d         = wr_q;
        col_d        = col_q;
        drain_row_d  = drain_row_q;
        wr_slot_d    = wr_slot_q;
        drain_slot_d = drain_slot_q;
        rows_left_d  = rows_left_q;
        oReady       = 1'b0;
        oValid       = 1'b0;
        oLast        = 1'b0;
        add_en       = 1'b0;
        clr_en       = 1'b0;
        unique case (state_q)
            ACCUM: begin
                oReady = 1'b1;
                if (iValid) begin
                    add_en = 1'b1;
                    if (wc_q == WC_LAST) begin
                        wc_d    = '0;
                        state_d = DRAIN;
                        if (wr_q == WR_LAST) begin
                            rows_left_d = 2'd3;
                        end else begin
                            rows_left_d = 2'd1;
                            wr_d        = wr_q + RW'(1);
                            wr_slot_d   = slotInc(wr_slot_q);
                        end
                    end else begin
                        wc_d = wc_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                oValid = 1'b1;
                oLast  = (drain_row_q == ROW_LAST) && (col_q == COL_LAST);
                if (iReady) begin
                    clr_en = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d        = '0;
                        drain_row_d  = drain_row_q + RW'(1);
                        drain_slot_d = slotInc(drain_slot_q);
                        rows_left_d  = rows_left_q - 2'd1;
                        if (rows_left_q == 2'd1) begin
                            state_d = ACCUM;
                            if (drain_row_q == ROW_LAST) begin
                                wr_d         = '0;
                                wc_d         = '0;
                                wr_slot_d    = '0;
                                drain_row_d  = '0;
                                drain_slot_d = '0;
                            end
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // Route each kernel row of the window to the buffer holding image row wr+kr.
    always_comb begin
        for (int b = 0; b < K; b++) begin
            lane_data[b] = '0;
            for (int kr = 0; kr < K; kr++) begin
                if (laneRow(b, int'(wr_slot_q)) == kr) begin
                    lane_data[b] = iData[elemIdx(kr, 0)*DATA_W +: K*DATA_W];
                end
            end
        end
    end

    for (genvar b = 0; b < K; b++) begin : g_row
        col2ImRowBuf #(
            .IMG_W (IMG_W),
            .DATA_W(DATA_W),
            .ACC_W (ACC_W),
            .CW    (CW)
        ) u_row (
            .clk_i     (iClk),
            .rst_ni    (iRst),
            .add_en_i  (add_en),
            .add_col_i (wc_q),
            .add_data_i(lane_data[b]),
            .clr_en_i  (clr_en && (drain_slot_q == 2'(b))),
            .rd_col_i  (col_q),
            .rd_data_o (rd_data[b])
        );
    end

    always_comb begin
        oData = '0;
        if (state_q == DRAIN) begin
            oData = rd_data[drain_slot_q];
        end
    end

endmodule

// File: tb/tb_col2im_accum.sv
// Directed bench for col2im_accum on a 5x5 image: table of whole-frame
// scenarios plus hand-written reset and back-to-back sequences.
module tb_col2im_accum;
    import col2ImPkg::*;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int DW   = 8;
    localparam int AW   = 12;
    localparam int NWIN = 9;
    localparam int NPIX = 25;

    logic                 iClk = 1'b0;
    logic                 iRst = 1'b0;
    logic [9*DW-1:0]      iData = '0;
    logic                 iValid = 1'b0;
    logic                 iReady = 1'b0;
    logic                 oReady, oValid, oLast;
    logic signed [AW-1:0] oData;

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    col2im_accum #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ACC_W(AW)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iData (iData),
        .iValid(iValid),
        .oReady(oReady),
        .oData (oData),
        .oValid(oValid),
        .iReady(iReady),
        .oLast (oLast)
    );

    typedef struct {
        int mode;     // 0: every element = val; 1: element 0 = window index
        int val;
        bit toggle;   // toggle iReady every cycle
        int img[NPIX];
    } vec_t;

    vec_t vecs[4];

    int ones_img[NPIX] = '{1, 2, 3, 2, 1,
                           2, 4, 6, 4, 2,
                           3, 6, 9, 6, 3,
                           2, 4, 6, 4, 2,
                           1, 2, 3, 2, 1};
    int neg_img[NPIX]  = '{-128, -256,  -384, -256, -128,
                           -256, -512,  -768, -512, -256,
                           -384, -768, -1152, -768, -384,
                           -256, -512,  -768, -512, -256,
                           -128, -256,  -384, -256, -128};
    int idx_img[NPIX]  = '{0, 1, 2, 0, 0,
                           3, 4, 5, 0, 0,
                           6, 7, 8, 0, 0,
                           0, 0, 0, 0, 0,
                           0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, req);
        end
    endtask

    function automatic logic [9*DW-1:0] win(input int mode, input int val, input int n);
        logic [9*DW-1:0] d;
        d = '0;
        for (int e = 0; e < 9; e++) begin
            if (mode == 0) d[e*DW +: DW] = DW'(val);
            else if (e == 0) d[e*DW +: DW] = DW'(n);
        end
        return d;
    endfunction

    // Feeds nwin windows and collects npix pixels, checking each against ref_img.
    task automatic run_frame(input int mode, input int val, input bit toggle,
                             input int nwin, input int npix, input int ref_img[NPIX]);
        int w = 0;
        int got = 0;
        int cyc = 0;
        bit tog = 1'b1;
        bit stalled = 1'b0;
        bit pend = 1'b0;
        logic signed [AW-1:0] held = '0;
        while ((w < nwin || got < npix) && cyc < 2000) begin
            @(negedge iClk);
            cyc++;
            iValid = (w < nwin);
            iData  = win(mode, val, w);
            iReady = toggle ? tog : 1'b1;
            tog    = ~tog;
            #1;
            if (pend) chk("first_pixel_latency", int'(oValid), 1);
            pend = 1'b0;
            if (stalled) begin
                chk("stall_valid_held", int'(oValid), 1);
                chk("stall_data_held", int'(oData), int'(held));
            end
            stalled = 1'b0;
            if (oValid) begin
                chk("ready_low_in_drain", int'(oReady), 0);
                if (iReady) begin
                    chk($sformatf("pix%0d", got), int'(oData), ref_img[got]);
                    chk($sformatf("last%0d", got), int'(oLast), int'(got == NPIX-1));
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = oData;
                end
            end else begin
                chk("last_without_valid", int'(oLast), 0);
            end
            if (iValid && oReady) begin
                pend = (w % 3 == 2);
                w++;
            end
        end
        chk("windows_accepted", w, nwin);
        chk("pixels_received", got, npix);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_oValid"}, int'(oValid), 0);
        chk({tag, "_oReady"}, int'(oReady), 1);
        chk({tag, "_oData"},  int'(oData),  0);
        chk({tag, "_oLast"},  int'(oLast),  0);
    endtask

    initial begin
        vecs[0].mode = 0; vecs[0].val = 1;    vecs[0].toggle = 1'b0; vecs[0].img = ones_img;
        vecs[1].mode = 0; vecs[1].val = -128; vecs[1].toggle = 1'b0; vecs[1].img = neg_img;
        vecs[2].mode = 1; vecs[2].val = 0;    vecs[2].toggle = 1'b0; vecs[2].img = idx_img;
        vecs[3].mode = 0; vecs[3].val = 1;    vecs[3].toggle = 1'b1; vecs[3].img = ones_img;

        iRst = 1'b0;
        repeat (3) @(negedge iClk);
        #1;
        chk_reset_outputs("por");
        @(negedge iClk);
        iRst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].mode, vecs[i].val, vecs[i].toggle, NWIN, NPIX, vecs[i].img);
        end

        // Back-to-back frames: second must match first, so zero-on-read cleared everything.
        run_frame(0, 1, 1'b0, NWIN, NPIX, ones_img);
        run_frame(0, 1, 1'b0, NWIN, NPIX, ones_img);

        // Reset while a row is draining.
        run_frame(0, 1, 1'b0, 3, 2, ones_img);
        @(negedge iClk);
        iValid = 1'b0;
        #1;
        chk("pre_reset_valid", int'(oValid), 1);
        iRst = 1'b0;
        #1;
        chk_reset_outputs("rst_drain");
        @(negedge iClk);
        iRst = 1'b1;
        run_frame(0, 1, 1'b0, NWIN, NPIX, ones_img);

        // Reset after four windows, then a clean full frame.
        run_frame(0, 1, 1'b0, 4, 5, ones_img);
        @(negedge iClk);
        iValid = 1'b0;
        #1;
        iRst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge iClk);
        iRst = 1'b1;
        run_frame(0, 1, 1'b0, NWIN, NPIX, ones_img);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
